fpga_bus: RTL and testbench

FPGA_BUS -- requirements
Module: fpga_bus

---
 rtl/fpga_bus_pkg.sv | 41 ++++
 rtl/fpga_bus_arbiter.sv | 25 ++
 rtl/fpga_bus.sv | 112 +++++++++++
 tb/tb_fpga_bus.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_bus_pkg.sv
// Shared constants, FSM state type and frame builder for the fpga_bus serial bus.
package fpga_bus_pkg;

    localparam int unsigned NODE_COUNT  = 16;
    localparam int unsigned FRAME_LEN   = 80;
    localparam int unsigned DEFAULT_GAP = 4;

    // Bit positions inside the 80-bit frame, MSB is transmitted first
    localparam int unsigned SOF_POS  = 79;
    localparam int unsigned SRC_MSB  = 78;
    localparam int unsigned DST_MSB  = 74;
    localparam int unsigned DATA_MSB = 70;
    localparam int unsigned CRC_MSB  = 6;
    localparam int unsigned ACK_POS  = 2;
    localparam int unsigned EOF_MSB  = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } state_t;

    typedef logic [FRAME_LEN-1:0] frame_t;

    function automatic frame_t build_frame(input logic [3:0]  src,
                                           input logic [3:0]  dst,
                                           input logic [63:0] data,
                                           input logic [3:0]  crc);
        frame_t f;
        f                 = '0;
        f[SOF_POS]        = 1'b0;
        f[SRC_MSB -: 4]   = src;
        f[DST_MSB -: 4]   = dst;
        f[DATA_MSB -: 64] = data;
        f[CRC_MSB -: 4]   = crc;
        f[ACK_POS]        = (dst != src);
        f[EOF_MSB -: 2]   = 2'b11;
        return f;
    endfunction

endpackage

// File: rtl/fpga_bus_arbiter.sv
// Fixed-priority request encoder: the lowest set request bit wins.
module fpga_bus_arbiter
    import fpga_bus_pkg::*;
#(
    parameter int unsigned NODES = NODE_COUNT
) (
    input  logic [NODES-1:0]         req,
    output logic [$clog2(NODES)-1:0] grant,
    output logic                     valid
);

    localparam int unsigned IDX_W = $clog2(NODES);

    // Scan from the top so the last hit (lowest index) wins
    always_comb begin
        grant = '0;
        valid = |req;
        for (int unsigned i = 0; i < NODES; i++) begin
            if (req[NODES-1-i]) begin
                grant = IDX_W'(NODES - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fpga_bus.sv
// Serial bus master: arbitrates 16 nodes, serialises the winner's 80-bit frame, then idles.
module fpga_bus
    import fpga_bus_pkg::*;
#(
    parameter int unsigned NODES = NODE_COUNT,
    parameter int unsigned GAP   = DEFAULT_GAP
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [3:0]       CRC1, CRC2, CRC3, CRC4, CRC5, CRC6, CRC7, CRC8,
                             CRC9, CRC10, CRC11, CRC12, CRC13, CRC14, CRC15, CRC16,
    input  logic [63:0]      Data1, Data2, Data3, Data4, Data5, Data6, Data7, Data8,
                             Data9, Data10, Data11, Data12, Data13, Data14, Data15, Data16,
    input  logic [3:0]       receiverAddr1, receiverAddr2, receiverAddr3, receiverAddr4,
                             receiverAddr5, receiverAddr6, receiverAddr7, receiverAddr8,
                             receiverAddr9, receiverAddr10, receiverAddr11, receiverAddr12,
                             receiverAddr13, receiverAddr14, receiverAddr15, receiverAddr16,
    input  logic [NODES-1:0] mod,
    output logic             bus_show
);

    localparam logic [6:0] LAST_BIT = 7'(FRAME_LEN - 1);
    // The IDLE sample cycle is the final gap cycle, so GAP spends GAP-1 cycles here
    localparam logic [6:0] GAP_LAST = 7'(GAP - 2);

    logic [3:0]  crc_arr  [NODES];
    logic [63:0] data_arr [NODES];
    logic [3:0]  dst_arr  [NODES];

    assign crc_arr  = '{CRC1, CRC2, CRC3, CRC4, CRC5, CRC6, CRC7, CRC8,
                        CRC9, CRC10, CRC11, CRC12, CRC13, CRC14, CRC15, CRC16};
    assign data_arr = '{Data1, Data2, Data3, Data4, Data5, Data6, Data7, Data8,
                        Data9, Data10, Data11, Data12, Data13, Data14, Data15, Data16};
    assign dst_arr  = '{receiverAddr1, receiverAddr2, receiverAddr3, receiverAddr4,
                        receiverAddr5, receiverAddr6, receiverAddr7, receiverAddr8,
                        receiverAddr9, receiverAddr10, receiverAddr11, receiverAddr12,
                        receiverAddr13, receiverAddr14, receiverAddr15, receiverAddr16};

    state_t     state;
    state_t     next_state;
    logic [6:0] cnt;
    frame_t     sreg;
    frame_t     frame_sel;
    logic [3:0] grant;
    logic       valid;
    logic       bus_next;

    fpga_bus_arbiter #(.NODES(NODES)) u_arbiter (
        .req   (mod),
        .grant (grant),
        .valid (valid)
    );

    assign frame_sel = build_frame(grant, dst_arr[grant], data_arr[grant], crc_arr[grant]);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (valid)             next_state = ST_SEND;
            ST_SEND: if (cnt == LAST_BIT)   next_state = ST_GAP;
            ST_GAP:  if (cnt == GAP_LAST)   next_state = ST_IDLE;
            default:                        next_state = ST_IDLE;
        endcase
    end

    // SOF leaves on the grant edge itself; the shift register holds the remaining 79 bits
    always_comb begin
        bus_next = 1'b1;
        case (state)
            ST_IDLE: if (valid)           bus_next = frame_sel[FRAME_LEN-1];
            ST_SEND: if (cnt != LAST_BIT) bus_next = sreg[FRAME_LEN-1];
            default:                      bus_next = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            sreg     <= '0;
            bus_show <= 1'b1;
        end else begin
            bus_show <= bus_next;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (valid) begin
                        sreg <= {frame_sel[FRAME_LEN-2:0], 1'b1};
                    end
                end
                ST_SEND: begin
                    if (cnt == LAST_BIT) begin
                        cnt <= '0;
                    end else begin
                        cnt  <= cnt + 7'd1;
                        sreg <= {sreg[FRAME_LEN-2:0], 1'b1};
                    end
                end
                ST_GAP:  cnt <= cnt + 7'd1;
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_fpga_bus.sv
// Scoreboard bench for fpga_bus: expected serial bits are queued at stimulus time and popped per cycle.
module tb_fpga_bus;

    localparam int GAP_CYC   = 4;
    localparam int FRAME_CYC = 80 + GAP_CYC;

    logic        clock;
    logic        reset_n;
    logic [3:0]  crc   [16];
    logic [63:0] data  [16];
    logic [3:0]  raddr [16];
    logic [15:0] mod;
    logic        bus_show;

    int   tests;
    int   fails;
    logic exp_q [$];
    logic exp_bit;

    fpga_bus #(.NODES(16), .GAP(GAP_CYC)) dut (
        .clock(clock), .reset_n(reset_n),
        .CRC1(crc[0]),   .CRC2(crc[1]),   .CRC3(crc[2]),   .CRC4(crc[3]),
        .CRC5(crc[4]),   .CRC6(crc[5]),   .CRC7(crc[6]),   .CRC8(crc[7]),
        .CRC9(crc[8]),   .CRC10(crc[9]),  .CRC11(crc[10]), .CRC12(crc[11]),
        .CRC13(crc[12]), .CRC14(crc[13]), .CRC15(crc[14]), .CRC16(crc[15]),
        .Data1(data[0]),   .Data2(data[1]),   .Data3(data[2]),   .Data4(data[3]),
        .Data5(data[4]),   .Data6(data[5]),   .Data7(data[6]),   .Data8(data[7]),
        .Data9(data[8]),   .Data10(data[9]),  .Data11(data[10]), .Data12(data[11]),
        .Data13(data[12]), .Data14(data[13]), .Data15(data[14]), .Data16(data[15]),
        .receiverAddr1(raddr[0]),   .receiverAddr2(raddr[1]),   .receiverAddr3(raddr[2]),
        .receiverAddr4(raddr[3]),   .receiverAddr5(raddr[4]),   .receiverAddr6(raddr[5]),
        .receiverAddr7(raddr[6]),   .receiverAddr8(raddr[7]),   .receiverAddr9(raddr[8]),
        .receiverAddr10(raddr[9]),  .receiverAddr11(raddr[10]), .receiverAddr12(raddr[11]),
        .receiverAddr13(raddr[12]), .receiverAddr14(raddr[13]), .receiverAddr15(raddr[14]),
        .receiverAddr16(raddr[15]),
        .mod(mod), .bus_show(bus_show)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [79:0] model_frame(input int src, input int dst,
                                                input logic [63:0] d, input logic [3:0] c);
        logic [3:0] s4;
        logic [3:0] d4;
        s4 = 4'(src);
        d4 = 4'(dst);
        return {1'b0, s4, d4, d, c, (s4 != d4), 2'b11};
    endfunction

    task automatic push_frame(input int src, input int dst, input logic [63:0] d, input logic [3:0] c);
        logic [79:0] f;
        f = model_frame(src, dst, d, c);
        for (int i = 79; i >= 0; i--) exp_q.push_back(f[i]);
        for (int i = 0; i < GAP_CYC; i++) exp_q.push_back(1'b1);
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        mod     = '0;
        for (int i = 0; i < 16; i++) begin
            crc[i] = '0; data[i] = '0; raddr[i] = '0;
        end
        #2 reset_n = 1'b0;
        #1;
        tests++;
        if (bus_show !== 1'b1) begin
            fails++;
            $display("FAIL reset_async: got %b expected 1", bus_show);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            tests++;
            if (bus_show !== 1'b1) begin
                fails++;
                $display("FAIL reset_idle cycle %0d: got %b expected 1", i, bus_show);
            end
        end
    endtask

    task automatic test_single();
        data[0] = 64'd1; crc[0] = 4'd1; raddr[0] = 4'd1;
        push_frame(0, 1, data[0], crc[0]);
        mod = 16'h0001;
        for (int i = 0; i < FRAME_CYC; i++) begin
            @(negedge clock);
            exp_bit = exp_q.pop_front();
            tests++;
            if (bus_show !== exp_bit) begin
                fails++;
                $display("FAIL single_frame bit %0d: got %b expected %b", i, bus_show, exp_bit);
            end
            if (i == FRAME_CYC - 1) mod = '0;
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            tests++;
            if (bus_show !== 1'b1) begin
                fails++;
                $display("FAIL single_idle cycle %0d: got %b expected 1", i, bus_show);
            end
        end
    endtask

    task automatic test_sequential();
        data[0] = 64'h0123_4567_89AB_CDEF; crc[0] = 4'h9; raddr[0] = 4'd1;
        data[1] = 64'hA5A5_5A5A_F00F_0FF0; crc[1] = 4'h3; raddr[1] = 4'd2;
        data[2] = 64'h8000_0000_0000_0001; crc[2] = 4'hC; raddr[2] = 4'd3;
        for (int k = 0; k < 3; k++) push_frame(k, k + 1, data[k], crc[k]);
        mod = 16'h0001;
        for (int i = 0; i < 3 * FRAME_CYC; i++) begin
            @(negedge clock);
            exp_bit = exp_q.pop_front();
            tests++;
            if (bus_show !== exp_bit) begin
                fails++;
                $display("FAIL sequential bit %0d: got %b expected %b", i, bus_show, exp_bit);
            end
            if (i == FRAME_CYC - 1)     mod = 16'h0002;
            if (i == 2 * FRAME_CYC - 1) mod = 16'h0004;
            if (i == 3 * FRAME_CYC - 1) mod = '0;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            tests++;
            if (bus_show !== 1'b1) begin
                fails++;
                $display("FAIL sequential_idle cycle %0d: got %b expected 1", i, bus_show);
            end
        end
    endtask

    task automatic test_contention();
        data[0] = 64'hFEDC_BA98_7654_3210; crc[0] = 4'h2; raddr[0] = 4'hE;
        data[2] = 64'h1357_9BDF_2468_ACE0; crc[2] = 4'hB; raddr[2] = 4'h7;
        push_frame(0, 14, data[0], crc[0]);
        push_frame(0, 14, data[0], crc[0]);
        push_frame(2, 7, data[2], crc[2]);
        mod = 16'h0005;
        for (int i = 0; i < 3 * FRAME_CYC; i++) begin
            @(negedge clock);
            exp_bit = exp_q.pop_front();
            tests++;
            if (bus_show !== exp_bit) begin
                fails++;
                $display("FAIL contention bit %0d: got %b expected %b", i, bus_show, exp_bit);
            end
            if (i == FRAME_CYC + 40)    mod = 16'h0004;
            if (i == 3 * FRAME_CYC - 1) mod = '0;
        end
    endtask

    task automatic test_midframe();
        data[0] = 64'hDEAD_BEEF_0BAD_F00D; crc[0] = 4'h6; raddr[0] = 4'hA;
        push_frame(0, 10, data[0], crc[0]);
        mod = 16'h0001;
        for (int i = 0; i < FRAME_CYC; i++) begin
            @(negedge clock);
            exp_bit = exp_q.pop_front();
            tests++;
            if (bus_show !== exp_bit) begin
                fails++;
                $display("FAIL midframe bit %0d: got %b expected %b", i, bus_show, exp_bit);
            end
            if (i == 20) begin
                data[0]  = ~data[0];
                crc[0]   = ~crc[0];
                raddr[0] = 4'h0;
                mod      = '0;
            end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            tests++;
            if (bus_show !== 1'b1) begin
                fails++;
                $display("FAIL midframe_idle cycle %0d: got %b expected 1", i, bus_show);
            end
        end
    endtask

    task automatic test_self_addr();
        data[4] = 64'h5555_AAAA_5555_AAAA; crc[4] = 4'hF; raddr[4] = 4'd4;
        push_frame(4, 4, data[4], crc[4]);
        mod = 16'h0010;
        for (int i = 0; i < FRAME_CYC; i++) begin
            @(negedge clock);
            exp_bit = exp_q.pop_front();
            tests++;
            if (bus_show !== exp_bit) begin
                fails++;
                $display("FAIL self_addr bit %0d: got %b expected %b", i, bus_show, exp_bit);
            end
            if (i == 77) begin
                tests++;
                if (bus_show !== 1'b0) begin
                    fails++;
                    $display("FAIL self_addr_ack: got %b expected 0", bus_show);
                end
            end
            if (i == FRAME_CYC - 1) mod = '0;
        end
    endtask

    task automatic test_reset_midframe();
        // Data bit 32 is 0, so bit 40 on the wire is 0 when reset hits
        data[0] = 64'hFFFF_FFFE_FFFF_FFFF; crc[0] = 4'h5; raddr[0] = 4'h3;
        push_frame(0, 3, data[0], crc[0]);
        mod = 16'h0001;
        for (int i = 0; i <= 40; i++) begin
            @(negedge clock);
            exp_bit = exp_q.pop_front();
            tests++;
            if (bus_show !== exp_bit) begin
                fails++;
                $display("FAIL reset_mid_pre bit %0d: got %b expected %b", i, bus_show, exp_bit);
            end
        end
        #1 reset_n = 1'b0;
        #1;
        tests++;
        if (bus_show !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_async: got %b expected 1", bus_show);
        end
        exp_q.delete();
        @(negedge clock);
        tests++;
        if (bus_show !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_held: got %b expected 1", bus_show);
        end
        reset_n = 1'b1;
        push_frame(0, 3, data[0], crc[0]);
        for (int i = 0; i < FRAME_CYC; i++) begin
            @(negedge clock);
            exp_bit = exp_q.pop_front();
            tests++;
            if (bus_show !== exp_bit) begin
                fails++;
                $display("FAIL reset_mid_restart bit %0d: got %b expected %b", i, bus_show, exp_bit);
            end
            if (i == FRAME_CYC - 1) mod = '0;
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_single();
        test_sequential();
        test_contention();
        test_midframe();
        test_self_addr();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
